// File: rtl/mem_bus_arbiter.sv
// Purpose: N-master to 1-slave arbiter for a picorv32-style native memory bus, with optional bus timeout.
// Latency: request seen in cycle 0 -> mem_valid in cycle 1; m_ready/m_rdata pass through combinationally.
// Backpressure: the granted master waits on mem_ready (or the timeout); other masters wait for the next arbitration.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RR_MODE     = 1,
    parameter int TIMEOUT     = 0,
    localparam int STRB_W     = DATA_W / 8,
    localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS-1:0]        m_instr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          mem_valid,
    output logic                          mem_instr,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [STRB_W-1:0]             mem_wstrb,
    input  logic                          mem_ready,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          err_valid,
    output logic [IDX_W-1:0]              err_idx,
    output logic [ADDR_W-1:0]             err_addr
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [31:0]         cnt_q, cnt_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_instr_q, mem_instr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                err_valid_q, err_valid_d;
    logic [IDX_W-1:0]    err_idx_q, err_idx_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    cand;
    logic                found;
    logic                to_hit;

    // Winner search: round-robin starts one past the last grant, fixed priority starts at index 0.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (RR_MODE != 0) begin
                cand = IDX_W'((int'(last_q) + 1 + k) % NUM_MASTERS);
            end else begin
                cand = IDX_W'(k);
            end
            if (!found && m_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Timeout fires on the last allowed waiting cycle; a real mem_ready in that cycle takes precedence.
    assign to_hit = (TIMEOUT > 0) && (state_q == BUSY) && !mem_ready
                    && (cnt_q == 32'(TIMEOUT - 1));

    // Completion pulse goes only to the owner; on timeout it is faked with zero read data.
    always_comb begin
        m_ready = '0;
        if ((state_q == BUSY) && (mem_ready || to_hit)) begin
            m_ready[grant_q] = 1'b1;
        end
        m_rdata = to_hit ? '0 : mem_rdata;
    end

    // Next-state logic for the arbitration FSM and all registered outputs.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        grant_d     = grant_q;
        err_valid_d = 1'b0;
        err_idx_d   = err_idx_q;
        err_addr_d  = err_addr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    mem_valid_d = 1'b1;
                    mem_instr_d = m_instr[win];
                    mem_addr_d  = m_addr[int'(win)*ADDR_W +: ADDR_W];
                    mem_wdata_d = m_wdata[int'(win)*DATA_W +: DATA_W];
                    mem_wstrb_d = m_wstrb[int'(win)*STRB_W +: STRB_W];
                    grant_d     = win;
                    if (RR_MODE != 0) begin
                        last_d = win;
                    end
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (to_hit) begin
                    mem_valid_d = 1'b0;
                    err_valid_d = 1'b1;
                    err_idx_d   = grant_q;
                    err_addr_d  = mem_addr_q;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any in-flight transaction silently.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_MASTERS - 1);
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            grant_q     <= '0;
            err_valid_q <= 1'b0;
            err_idx_q   <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            grant_q     <= grant_d;
            err_valid_q <= err_valid_d;
            err_idx_q   <= err_idx_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_instr = mem_instr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign grant_idx = grant_q;
    assign err_valid = err_valid_q;
    assign err_idx   = err_idx_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: directed bench for mem_bus_arbiter (round-robin with timeout, plus a fixed-priority instance).
// Latency: expected grants queued when requests are driven, popped when mem_valid appears.
// Backpressure: slave readiness is driven directly by the stimulus sequence.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        resetn;

    // Round-robin instance with timeout
    logic [2:0]  m_valid, m_instr, m_ready;
    logic [95:0] m_addr, m_wdata;
    logic [11:0] m_wstrb;
    logic [31:0] m_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  grant_idx, err_idx;
    logic        err_valid;
    logic [31:0] err_addr;

    // Fixed-priority instance without timeout
    logic [2:0]  f_m_valid, f_m_instr, f_m_ready;
    logic [95:0] f_m_addr, f_m_wdata;
    logic [11:0] f_m_wstrb;
    logic [31:0] f_m_rdata;
    logic        f_mem_valid, f_mem_instr, f_mem_ready;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [3:0]  f_mem_wstrb;
    logic [1:0]  f_grant_idx, f_err_idx;
    logic        f_err_valid;
    logic [31:0] f_err_addr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } exp_t;

    exp_t sb[$];
    int   fq[$];
    exp_t cur;

    mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_idx(grant_idx), .err_valid(err_valid), .err_idx(err_idx), .err_addr(err_addr)
    );

    mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(0)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m_valid(f_m_valid), .m_instr(f_m_instr), .m_addr(f_m_addr), .m_wdata(f_m_wdata), .m_wstrb(f_m_wstrb),
        .m_ready(f_m_ready), .m_rdata(f_m_rdata),
        .mem_valid(f_mem_valid), .mem_instr(f_mem_instr), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_wstrb(f_mem_wstrb), .mem_ready(f_mem_ready), .mem_rdata(f_mem_rdata),
        .grant_idx(f_grant_idx), .err_valid(f_err_valid), .err_idx(f_err_idx), .err_addr(f_err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ins, input bit push);
        exp_t e;
        m_valid[i]          = 1'b1;
        m_instr[i]          = ins;
        m_addr[i*32 +: 32]  = a;
        m_wdata[i*32 +: 32] = wd;
        m_wstrb[i*4 +: 4]   = ws;
        if (push) begin
            e = '{idx: i, addr: a, wdata: wd, wstrb: ws, instr: ins};
            sb.push_back(e);
        end
    endtask

    // Pops the next expected grant and compares the bus payload against it.
    task automatic chk_grant();
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
        end else begin
            cur = sb.pop_front();
            chk("mem_valid", 64'(mem_valid), 64'd1);
            chk("grant_idx", 64'(grant_idx), 64'(cur.idx));
            chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
            chk("mem_wstrb", 64'(mem_wstrb), 64'(cur.wstrb));
            chk("mem_instr", 64'(mem_instr), 64'(cur.instr));
        end
    endtask

    // Waits for the grant, holds the slave busy for lat cycles, then completes with rd.
    task automatic serve(input int lat, input logic [31:0] rd, input logic [2:0] drop);
        int n = 0;
        while (!mem_valid && n < 10) begin
            tick();
            n++;
        end
        chk("lat_to_valid", 64'(n), 64'd1);
        chk_grant();
        for (int c = 0; c < lat; c++) begin
            tick();
            chk("hold_addr", 64'(mem_addr), 64'(cur.addr));
            chk("hold_wdata", 64'(mem_wdata), 64'(cur.wdata));
            chk("hold_wstrb", 64'(mem_wstrb), 64'(cur.wstrb));
            chk("wait_m_ready", 64'(m_ready), 64'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        #1;
        chk("m_ready_pulse", 64'(m_ready), 64'(3'b001 << cur.idx));
        chk("m_rdata", 64'(m_rdata), 64'(rd));
        tick();
        mem_ready = 1'b0;
        m_valid   = m_valid & ~drop;
        #1;
        chk("done_mem_valid", 64'(mem_valid), 64'd0);
        chk("done_m_ready", 64'(m_ready), 64'd0);
        chk("done_err", 64'(err_valid), 64'd0);
    endtask

    task automatic f_pop();
        int e;
        if (fq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL fp_underflow: observed empty queue expected an entry");
        end else begin
            e = fq.pop_front();
            chk("fp_valid", 64'(f_mem_valid), 64'd1);
            chk("fp_grant", 64'(f_grant_idx), 64'(e));
            chk("fp_addr", 64'(f_mem_addr), 64'(32'hA0 + e));
        end
    endtask

    initial begin
        resetn    = 1'b0;
        m_valid   = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        f_m_valid = '0; f_m_instr = '0; f_m_wdata = '0; f_m_wstrb = '0;
        f_m_addr  = {32'hA2, 32'hA1, 32'hA0};
        f_mem_ready = 1'b1; f_mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        chk("rst_err_valid", 64'(err_valid), 64'd0);
        chk("rst_err_idx", 64'(err_idx), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_m_ready", 64'(m_ready), 64'd0);
        resetn = 1'b1;
        tick();

        // Single read from master 0
        req(0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
        serve(3, 32'hDEADBEEF, 3'b001);

        // Write payload from master 1
        req(1, 32'h2000, 32'h12345678, 4'hC, 1'b0, 1'b1);
        serve(3, 32'h0, 3'b010);

        // Timeout on master 2 (instruction fetch)
        req(2, 32'h3000, 32'h0, 4'h0, 1'b1, 1'b1);
        mem_rdata = 32'hFFFFFFFF;
        tick();
        chk_grant();
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("to_wait_m_ready", 64'(m_ready), 64'd0);
            chk("to_wait_err", 64'(err_valid), 64'd0);
        end
        tick();
        chk("to_m_ready", 64'(m_ready), 64'(3'b100));
        chk("to_m_rdata", 64'(m_rdata), 64'd0);
        tick();
        m_valid[2] = 1'b0;
        #1;
        chk("to_mem_valid", 64'(mem_valid), 64'd0);
        chk("to_err_valid", 64'(err_valid), 64'd1);
        chk("to_err_idx", 64'(err_idx), 64'd2);
        chk("to_err_addr", 64'(err_addr), 64'(32'h3000));
        chk("to_after_m_ready", 64'(m_ready), 64'd0);
        tick();
        chk("to_pulse_end", 64'(err_valid), 64'd0);
        chk("to_err_idx_hold", 64'(err_idx), 64'd2);

        // mem_ready on the threshold cycle completes normally
        req(0, 32'h4000, 32'h0, 4'h0, 1'b0, 1'b1);
        tick();
        chk_grant();
        for (int c = 0; c < 6; c++) tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h55AA55AA;
        #1;
        chk("thr_m_ready", 64'(m_ready), 64'(3'b001));
        chk("thr_m_rdata", 64'(m_rdata), 64'(32'h55AA55AA));
        tick();
        mem_ready  = 1'b0;
        m_valid[0] = 1'b0;
        #1;
        chk("thr_no_err", 64'(err_valid), 64'd0);
        chk("thr_mem_valid", 64'(mem_valid), 64'd0);
        chk("thr_err_addr_hold", 64'(err_addr), 64'(32'h3000));

        // Async reset in the middle of a BUSY cycle
        req(1, 32'h5000, 32'h0, 4'h0, 1'b0, 1'b1);
        tick();
        chk_grant();
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_mem_valid", 64'(mem_valid), 64'd0);
        chk("arst_grant", 64'(grant_idx), 64'd0);
        chk("arst_err_valid", 64'(err_valid), 64'd0);
        mem_ready = 1'b1;
        #1;
        chk("idle_ready_ignored", 64'(m_ready), 64'd0);
        tick();
        mem_ready = 1'b0;
        resetn    = 1'b1;

        // Round-robin fairness with all masters requesting continuously
        for (int i = 0; i < 3; i++) req(i, 32'h10 * (i + 1), 32'hC0DE0000 + i, 4'hF, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++)
                sb.push_back('{idx: i, addr: 32'h10 * (i + 1), wdata: 32'hC0DE0000 + i, wstrb: 4'hF, instr: 1'b0});
        for (int k = 0; k < 6; k++) serve(0, 32'h1000 + k, (k == 5) ? 3'b111 : 3'b000);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Fixed priority: master 1 served, then master 0 preempts master 2
        f_m_valid = 3'b110;
        fq.push_back(1);
        tick();
        f_pop();
        chk("fp_m_ready", 64'(f_m_ready), 64'(3'b010));
        f_m_valid = 3'b111;
        fq.push_back(0);
        tick();
        chk("fp_gap", 64'(f_mem_valid), 64'd0);
        f_m_valid = 3'b101;
        tick();
        f_pop();
        f_m_valid = 3'b100;
        fq.push_back(2);
        tick();
        chk("fp_gap2", 64'(f_mem_valid), 64'd0);
        tick();
        f_pop();
        f_m_valid = 3'b000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
